// File: rtl/vred_stream_unit.sv
// vred_stream_unit: multi-beat vector reduction (sum/and/or/xor/minu/min/maxu/max) with
// per-element masking, folding packed beats plus a scalar seed into one SEW-wide result.
// Optional build macro VRED_MINMAX_EN: when defined, opcodes 1xx (min/max family) are
// implemented; when undefined they still consume beats, return the truncated seed and
// raise out_illegal alongside out_valid.
module vred_stream_unit #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned OPSEL_WIDTH = 3,
    parameter int unsigned SEW_WIDTH   = 2,
    parameter int unsigned MASK_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [OPSEL_WIDTH-1:0] start_op,
    input  logic [SEW_WIDTH-1:0]   start_sew,
    input  logic [63:0]            start_seed,
    input  logic                   start_novl,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [MASK_WIDTH-1:0]  in_mask,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_result,
    output logic                   out_illegal
);

    localparam int unsigned EW     = 64;
    localparam int unsigned N8     = DATA_WIDTH / 8;
    localparam int unsigned N16    = DATA_WIDTH / 16;
    localparam int unsigned N32    = DATA_WIDTH / 32;
    localparam int unsigned N64    = DATA_WIDTH / 64;
    localparam int unsigned LEVELS = $clog2(MASK_WIDTH);

    localparam logic [OPSEL_WIDTH-1:0] OP_SUM  = OPSEL_WIDTH'(0);
    localparam logic [OPSEL_WIDTH-1:0] OP_AND  = OPSEL_WIDTH'(1);
    localparam logic [OPSEL_WIDTH-1:0] OP_OR   = OPSEL_WIDTH'(2);
    localparam logic [OPSEL_WIDTH-1:0] OP_XOR  = OPSEL_WIDTH'(3);
`ifdef VRED_MINMAX_EN
    localparam logic [OPSEL_WIDTH-1:0] OP_MINU = OPSEL_WIDTH'(4);
    localparam logic [OPSEL_WIDTH-1:0] OP_MIN  = OPSEL_WIDTH'(5);
    localparam logic [OPSEL_WIDTH-1:0] OP_MAXU = OPSEL_WIDTH'(6);
    localparam logic [OPSEL_WIDTH-1:0] OP_MAX  = OPSEL_WIDTH'(7);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [OPSEL_WIDTH-1:0]  op_q;
    logic [SEW_WIDTH-1:0]    sew_q;
    logic [EW-1:0]           acc;
    logic [EW-1:0]           s1_val;
    logic [EW-1:0]           s1_nxt;
    logic                    s1_valid;
    logic                    start_fire;
    logic                    beat_fire;
    logic                    start_illegal;
    logic                    run_illegal;
    logic [DATA_WIDTH-1:0]   result_nxt;
    logic                    illegal_nxt;

    // All-ones mask of the selected element width
    function automatic logic [EW-1:0] sew_mask(input logic [SEW_WIDTH-1:0] sew);
        case (sew)
            SEW_WIDTH'(0): return 64'h0000_0000_0000_00FF;
            SEW_WIDTH'(1): return 64'h0000_0000_0000_FFFF;
            SEW_WIDTH'(2): return 64'h0000_0000_FFFF_FFFF;
            default:       return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

`ifdef VRED_MINMAX_EN
    // Sign bit of the selected element width; XOR with it maps signed order onto unsigned order
    function automatic logic [EW-1:0] sign_bit(input logic [SEW_WIDTH-1:0] sew);
        return sew_mask(sew) ^ (sew_mask(sew) >> 1);
    endfunction
`endif

    // Value a masked-off element is replaced with so it cannot affect the result
    function automatic logic [EW-1:0] identity(input logic [OPSEL_WIDTH-1:0] op,
                                               input logic [SEW_WIDTH-1:0]   sew);
        case (op)
            OP_AND:  return sew_mask(sew);
`ifdef VRED_MINMAX_EN
            OP_MINU: return sew_mask(sew);
            OP_MIN:  return sew_mask(sew) >> 1;
            OP_MAX:  return sign_bit(sew);
`endif
            default: return '0;
        endcase
    endfunction

    // Binary reduction operator on two SEW-truncated operands
    function automatic logic [EW-1:0] combine(input logic [OPSEL_WIDTH-1:0] op,
                                              input logic [SEW_WIDTH-1:0]   sew,
                                              input logic [EW-1:0]          a,
                                              input logic [EW-1:0]          b);
`ifdef VRED_MINMAX_EN
        logic [EW-1:0] sb;
        sb = sign_bit(sew);
`endif
        case (op)
            OP_SUM:  return (a + b) & sew_mask(sew);
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
`ifdef VRED_MINMAX_EN
            OP_MINU: return (a < b) ? a : b;
            OP_MAXU: return (a > b) ? a : b;
            OP_MIN:  return ((a ^ sb) < (b ^ sb)) ? a : b;
            OP_MAX:  return ((a ^ sb) > (b ^ sb)) ? a : b;
`endif
            default: return a;
        endcase
    endfunction

    // Mask-substitute every element of a beat, then fold them with a log2 tree
    function automatic logic [EW-1:0] beat_reduce(input logic [DATA_WIDTH-1:0]  data,
                                                  input logic [MASK_WIDTH-1:0]  mask,
                                                  input logic [OPSEL_WIDTH-1:0] op,
                                                  input logic [SEW_WIDTH-1:0]   sew);
        logic [MASK_WIDTH-1:0][EW-1:0] lv;
        logic [EW-1:0]                 ident;
        ident = identity(op, sew);
        for (int i = 0; i < int'(MASK_WIDTH); i++) lv[i] = ident;
        case (sew)
            SEW_WIDTH'(0): for (int i = 0; i < int'(N8); i++)  if (mask[i]) lv[i] = EW'(data[i*8 +: 8]);
            SEW_WIDTH'(1): for (int i = 0; i < int'(N16); i++) if (mask[i]) lv[i] = EW'(data[i*16 +: 16]);
            SEW_WIDTH'(2): for (int i = 0; i < int'(N32); i++) if (mask[i]) lv[i] = EW'(data[i*32 +: 32]);
            default:       for (int i = 0; i < int'(N64); i++) if (mask[i]) lv[i] = data[i*64 +: 64];
        endcase
        for (int l = 0; l < int'(LEVELS); l++) begin
            for (int i = 0; i < int'(MASK_WIDTH / 2); i++) begin
                if (i < (int'(MASK_WIDTH) >> (l + 1))) lv[i] = combine(op, sew, lv[2*i], lv[2*i+1]);
            end
        end
        return lv[0];
    endfunction

    assign start_fire = start_valid & start_ready;
    assign beat_fire  = in_valid & in_ready;
    assign s1_nxt     = beat_reduce(in_data, in_mask, op_q, sew_q);

`ifdef VRED_MINMAX_EN
    assign start_illegal = 1'b0;
    assign run_illegal   = 1'b0;
`else
    assign start_illegal = start_op[2];
    assign run_illegal   = op_q[2];
`endif

    // Next-state and next-output decode
    always_comb begin
        state_nxt   = state;
        result_nxt  = out_result;
        illegal_nxt = out_illegal;
        case (state)
            S_IDLE: begin
                if (start_fire) begin
                    if (start_novl) begin
                        state_nxt   = S_DONE;
                        result_nxt  = DATA_WIDTH'(start_seed & sew_mask(start_sew));
                        illegal_nxt = start_illegal;
                    end else begin
                        state_nxt = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (beat_fire && in_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Accumulator already holds the last beat once stage 1 has emptied
                if (!s1_valid) begin
                    state_nxt   = S_DONE;
                    result_nxt  = DATA_WIDTH'(acc);
                    illegal_nxt = run_illegal;
                end
            end
            default: begin
                if (out_ready) begin
                    state_nxt   = S_IDLE;
                    illegal_nxt = 1'b0;
                end
            end
        endcase
    end

    // State register and registered handshake/result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            start_ready <= 1'b1;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_illegal <= 1'b0;
        end else begin
            state       <= state_nxt;
            start_ready <= (state_nxt == S_IDLE);
            in_ready    <= (state_nxt == S_ACCUM);
            out_valid   <= (state_nxt == S_DONE);
            out_result  <= result_nxt;
            out_illegal <= illegal_nxt;
        end
    end

    // Stage 1: per-beat masked tree reduction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_val   <= '0;
        end else begin
            s1_valid <= beat_fire;
            if (beat_fire) s1_val <= s1_nxt;
        end
    end

    // Stage 2: request latch and accumulator fold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q  <= '0;
            sew_q <= '0;
            acc   <= '0;
        end else if (start_fire) begin
            op_q  <= start_op;
            sew_q <= start_sew;
            acc   <= start_seed & sew_mask(start_sew);
        end else if (s1_valid && !run_illegal) begin
            acc <= combine(op_q, sew_q, acc, s1_val);
        end
    end

endmodule

// File: tb/tb_vred_stream_unit.sv
// Bench for vred_stream_unit: directed reductions checked against a sequential fold model,
// plus literal expectations, latency, backpressure and mid-reduction reset checks.
module tb_vred_stream_unit;

    localparam int unsigned DW = 64;
    localparam int unsigned MW = DW / 8;
`ifdef VRED_MINMAX_EN
    localparam bit MINMAX = 1'b1;
`else
    localparam bit MINMAX = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [2:0]    start_op;
    logic [1:0]    start_sew;
    logic [63:0]   start_seed;
    logic          start_novl;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [MW-1:0] in_mask;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic          out_illegal;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [63:0]   exp_res_q[$];
    logic          exp_ill_q[$];
    logic [63:0]   bd[4];
    logic [7:0]    bm[4];
    logic [63:0]   res;
    logic          ill;
    int            lat;

    vred_stream_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_op    (start_op),
        .start_sew   (start_sew),
        .start_seed  (start_seed),
        .start_novl  (start_novl),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mask     (in_mask),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Sign-extend a w-bit value for signed ordering
    function automatic longint sx(input logic [63:0] x, input int w);
        return longint'(x << (64 - w)) >>> (64 - w);
    endfunction

    // Sequential fold over enabled elements of bd/bm; masked elements are simply skipped
    function automatic logic [63:0] model(input logic [2:0] op, input logic [1:0] sew,
                                          input logic [63:0] seed, input int nb);
        int          w;
        logic [63:0] m;
        logic [63:0] acc;
        logic [63:0] e;
        w   = 8 << sew;
        m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        acc = seed & m;
        if (op[2] && !MINMAX) return acc;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 64 / w; i++) begin
                if (bm[b][i]) begin
                    e = (bd[b] >> (i * w)) & m;
                    case (op)
                        3'd0: acc = (acc + e) & m;
                        3'd1: acc = acc & e;
                        3'd2: acc = acc | e;
                        3'd3: acc = acc ^ e;
                        3'd4: acc = (e < acc) ? e : acc;
                        3'd5: acc = (sx(e, w) < sx(acc, w)) ? e : acc;
                        3'd6: acc = (e > acc) ? e : acc;
                        default: acc = (sx(e, w) > sx(acc, w)) ? e : acc;
                    endcase
                end
            end
        end
        return acc;
    endfunction

    // Check every cycle the result is presented; retire the expectation on the handshake
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_res_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got %h, expected no result pending", out_result);
            end else begin
                check64("scoreboard_result", out_result, exp_res_q[0]);
                check1("scoreboard_illegal", out_illegal, exp_ill_q[0]);
                if (out_ready) begin
                    void'(exp_res_q.pop_front());
                    void'(exp_ill_q.pop_front());
                end
            end
        end
    end

    // One full reduction: start, beats back-to-back, optional output stall, handshake
    task automatic reduce(input logic [2:0] op, input logic [1:0] sew, input logic [63:0] seed,
                          input logic novl, input int nb, input int hold,
                          output logic [63:0] r, output logic il, output int lt);
        int          guard;
        logic [63:0] e_res;
        r     = '0;
        il    = 1'b0;
        lt    = 0;
        e_res = model(op, sew, seed, novl ? 0 : nb);
        exp_res_q.push_back(e_res);
        exp_ill_q.push_back(op[2] && !MINMAX);
        out_ready = (hold == 0);
        guard = 0;
        while (!start_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        start_valid = 1'b1; start_op = op; start_sew = sew; start_seed = seed; start_novl = novl;
        @(posedge clk); #1;
        start_valid = 1'b0;
        start_novl  = 1'b0;
        if (novl) begin
            // A beat offered now must be ignored
            in_valid = 1'b1; in_data = bd[0]; in_mask = '1; in_last = 1'b1;
        end else begin
            for (int b = 0; b < nb; b++) begin
                in_valid = 1'b1; in_data = bd[b]; in_mask = bm[b]; in_last = (b == nb - 1);
                @(negedge clk);
                check1($sformatf("beat%0d_in_ready", b), in_ready, 1'b1);
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        do begin
            @(negedge clk);
            lt++;
        end while (!out_valid && lt < 20);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL result_timeout: got no out_valid after %0d cycles, expected one", lt);
        end else begin
            r  = out_result;
            il = out_illegal;
            for (int k = 0; k < hold; k++) begin
                check1("hold_out_valid", out_valid, 1'b1);
                check64("hold_out_result", out_result, e_res);
                check1("hold_start_ready", start_ready, 1'b0);
                check1("hold_in_ready", in_ready, 1'b0);
                @(negedge clk);
            end
            if (hold > 0) begin
                @(posedge clk); #1;
                out_ready = 1'b1;
                @(negedge clk);
            end
            @(posedge clk);
            @(negedge clk);
            check1("post_hs_out_valid", out_valid, 1'b0);
            check1("post_hs_start_ready", start_ready, 1'b1);
        end
    endtask

    initial begin
        rst = 1'b0;
        start_valid = 1'b0; start_op = '0; start_sew = '0; start_seed = '0; start_novl = 1'b0;
        in_valid = 1'b0; in_data = '0; in_mask = '0; in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check1("reset_out_valid", out_valid, 1'b0);
        check64("reset_out_result", out_result, 64'h0);
        check1("reset_out_illegal", out_illegal, 1'b0);
        check1("reset_in_ready", in_ready, 1'b0);
        check1("reset_start_ready", start_ready, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;

        // sum, sew=8: 1+2+..+8 + 5 = 0x29, three-cycle latency
        bd[0] = 64'h0102030405060708; bm[0] = 8'hFF;
        reduce(3'd0, 2'd0, 64'h05, 1'b0, 1, 0, res, ill, lat);
        check64("sum8_value", res, 64'h29);
        check64("sum8_latency", 64'(lat), 64'd3);

        // max / maxu, sew=16
        bd[0] = 64'h80017FFE0003FFFF; bm[0] = 8'h0F;
        reduce(3'd7, 2'd1, 64'h8000, 1'b0, 1, 0, res, ill, lat);
`ifdef VRED_MINMAX_EN
        check64("max16_m0f", res, 64'h7FFE);
`else
        check64("max16_m0f_seed", res, 64'h8000);
        check1("max16_m0f_illegal", ill, 1'b1);
`endif
        bm[0] = 8'h0B;
        reduce(3'd7, 2'd1, 64'h8000, 1'b0, 1, 0, res, ill, lat);
`ifdef VRED_MINMAX_EN
        check64("max16_m0b", res, 64'h0003);
`else
        check64("max16_m0b_seed", res, 64'h8000);
`endif
        bm[0] = 8'h0F;
        reduce(3'd6, 2'd1, 64'h8000, 1'b0, 1, 0, res, ill, lat);
`ifdef VRED_MINMAX_EN
        check64("maxu16_m0f", res, 64'hFFFF);
        check1("maxu16_illegal", ill, 1'b0);
`else
        check64("maxu16_m0f_seed", res, 64'h8000);
`endif

        // sum wrap at sew=32 across two back-to-back beats
        bd[0] = 64'h0000000100000001; bm[0] = 8'hFF;
        bd[1] = 64'h0000000100000001; bm[1] = 8'hFF;
        reduce(3'd0, 2'd2, 64'hFFFFFFFF, 1'b0, 2, 0, res, ill, lat);
        check64("sum32_wrap", res, 64'h00000003);

        // Output backpressure for five cycles (or, sew=8: 0x0F | 0x11 = 0x1F)
        bd[0] = 64'h1111111111111111; bm[0] = 8'h03;
        reduce(3'd2, 2'd0, 64'h0F, 1'b0, 1, 5, res, ill, lat);
        check64("or8_backpressure", res, 64'h1F);

        // vl=0: truncated seed one cycle after the start handshake
        bd[0] = 64'hFFFFFFFFFFFFFFFF;
        reduce(3'd0, 2'd1, 64'hABCD1234, 1'b1, 0, 0, res, ill, lat);
        check64("novl_value", res, 64'h1234);
        check64("novl_latency", 64'(lat), 64'd1);

        // and, sew=8, upper elements only
        bd[0] = 64'hF0F1F3F7FFFFFFFF; bm[0] = 8'hF0;
        reduce(3'd1, 2'd0, 64'hFF, 1'b0, 1, 0, res, ill, lat);
        check64("and8_value", res, 64'hF0);

        // xor, sew=16, mask bits above element count ignored
        bd[0] = 64'h000F00F00F00F000; bm[0] = 8'hFF;
        bd[1] = 64'hFFFF000000000000; bm[1] = 8'h08;
        reduce(3'd3, 2'd1, 64'h1234, 1'b0, 2, 0, res, ill, lat);

        // minu, sew=32
        bd[0] = 64'h7FFFFFFF90000000; bm[0] = 8'h03;
        reduce(3'd4, 2'd2, 64'h80000000, 1'b0, 1, 0, res, ill, lat);

        // all-zero mask contributes nothing but still ends the reduction
        bd[0] = 64'hFFFFFFFFFFFFFFFF; bm[0] = 8'h00;
        reduce(3'd2, 2'd0, 64'h5A, 1'b0, 1, 0, res, ill, lat);
        check64("zero_mask_value", res, 64'h5A);

        // Reset in the middle of a reduction after one accepted beat
        @(posedge clk); #1;
        start_valid = 1'b1; start_op = 3'd0; start_sew = 2'd0; start_seed = 64'h1; start_novl = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        in_valid = 1'b1; in_data = 64'h0101010101010101; in_mask = 8'hFF; in_last = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check1("accum_in_ready", in_ready, 1'b1);
        #2 rst = 1'b0;
        #1;
        check1("midrst_out_valid", out_valid, 1'b0);
        check64("midrst_out_result", out_result, 64'h0);
        check1("midrst_out_illegal", out_illegal, 1'b0);
        check1("midrst_in_ready", in_ready, 1'b0);
        check1("midrst_start_ready", start_ready, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;

        // Fresh reduction after reset: sew=64, seed 0, one beat of 7
        bd[0] = 64'h7; bm[0] = 8'hFF;
        reduce(3'd0, 2'd3, 64'h0, 1'b0, 1, 0, res, ill, lat);
        check64("sum64_after_reset", res, 64'h7);

        // min, sew=8: signed minimum is 0x80
        bd[0] = 64'h80FF017F00000000; bm[0] = 8'hF0;
        reduce(3'd5, 2'd0, 64'h10, 1'b0, 1, 0, res, ill, lat);
`ifdef VRED_MINMAX_EN
        check64("min8_value", res, 64'h80);
        check1("min8_illegal", ill, 1'b0);
`else
        check64("min8_seed", res, 64'h10);
        check1("min8_illegal", ill, 1'b1);
`endif

        repeat (2) @(negedge clk);
        check64("scoreboard_drained", 64'(exp_res_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
